// File: rtl/wb_pkg.sv
`timescale 1ns/1ps
// Shared defaults and types for the writeback arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    // Register 0 is hard-wired zero in the register file; writes to it are dropped.
    localparam int ZERO_REG   = 0;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;
endpackage

// File: rtl/rr_arb2.sv
`timescale 1ns/1ps
// Two-way round-robin arbiter with its last-grant pointer flop.
// Latency: ready is combinational from valid/freeze; pointer updates at the transfer edge.
// Backpressure: freeze or rst forces both readies low; a tied loser waits one cycle.
module rr_arb2
    import wb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    freeze,
    input  logic    a_valid,
    input  logic    b_valid,
    output logic    a_ready,
    output logic    b_ready,
    output logic    grant_vld,
    output req_id_t grant_id
);

    req_id_t last_q;
    logic    pick_a;
    logic    pick_b;

    // Select a winner: A wins alone or on a tie when B was served last.
    always_comb begin
        pick_a    = a_valid && (!b_valid || (last_q == REQ_B));
        pick_b    = b_valid && !pick_a;
        a_ready   = !rst && !freeze && pick_a;
        b_ready   = !rst && !freeze && pick_b;
        grant_vld = a_ready || b_ready;
        grant_id  = b_ready ? REQ_B : REQ_A;
    end

    // Pointer moves only on a completed transfer; reset favours A for the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= REQ_B;
        end else if (grant_vld) begin
            last_q <= grant_id;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
`timescale 1ns/1ps
// Writeback arbiter: merges ALU and load writebacks into one register-file write port.
// Latency: 1 cycle from transfer to regWrite/writeReg/writeData; optional bypass is combinational.
// Backpressure: one requester served per cycle, none while freeze; WB_BYPASS_EN adds forwarding.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              fwd_hit_1,
    output logic [DATA_W-1:0] fwd_data_1,
    output logic              fwd_hit_2,
    output logic [DATA_W-1:0] fwd_data_2
`endif
);

    logic              grant_vld;
    req_id_t           grant_id;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;
    logic              sel_live;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .a_ready   (a_ready),
        .b_ready   (b_ready),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    // Steer the granted requester's index/data; zero-index transfers are accepted but dropped.
    always_comb begin
        sel_reg  = (grant_id == REQ_B) ? b_reg  : a_reg;
        sel_data = (grant_id == REQ_B) ? b_data : a_data;
        sel_live = grant_vld && (sel_reg != ADDR_W'(ZERO_REG));
    end

    // Output register: write enable pulses per transfer; index/data hold between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else begin
            regWrite <= sel_live;
            if (sel_live) begin
                writeReg  <= sel_reg;
                writeData <= sel_data;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Forward the in-flight write to each read port whose index matches a live, nonzero target.
    always_comb begin
        fwd_hit_1  = regWrite && (writeReg == rs) && (rs != ADDR_W'(ZERO_REG));
        fwd_hit_2  = regWrite && (writeReg == rt) && (rt != ADDR_W'(ZERO_REG));
        fwd_data_1 = fwd_hit_1 ? writeData : '0;
        fwd_data_2 = fwd_hit_2 ? writeData : '0;
    end
`endif

endmodule
